dmem_responder: RTL and testbench

//  Data-memory responder for the rv32is data port: services loads and stores

---
 rtl/dmem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, sub-word load/store, post-reset clear.
// Optional macro DMEM_ALIGN_CHECK_EN suppresses misaligned accesses and pulses dmemerr.
module dmem_responder #(
   parameter int unsigned AW       = 10,
   parameter bit          CLEAR_EN = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemdatain,
   input  logic [2:0]  dmemop,
   input  logic        dmemwe,
   input  logic        dmemrdclk,
   input  logic        dmemwrclk,
   output logic [31:0] dmemdataout,
   output logic        dmemready,
   output logic        dmemerr
);

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_READ, S_RMW} state_t;
   localparam state_t RST_STATE = CLEAR_EN ? S_CLEAR : S_IDLE;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW+1:0] addr_q, addr_d, pend_addr_q, pend_addr_d;
   logic [2:0]    op_q, op_d, pend_op_q, pend_op_d;
   logic [15:0]   data_q, data_d;
   logic [31:0]   dout_q, dout_d;
   logic          pend_q, pend_d, ready_q, ready_d, err_q, err_d;
   logic          rd_q, wr_q;

   logic [31:0]   mem [2**AW];
   logic [31:0]   ram_rdata_q, ram_wdata;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic          ram_we;

   logic          rd_req, wr_req;
   logic [2:0]    st_op, ld_op;
   logic [AW+1:0] ld_addr;
   logic          unused_addr;

   function automatic logic [2:0] norm_op(input logic [2:0] op);
      logic [2:0] r;
      unique case (op)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: r = op;
         default: r = 3'b010;
      endcase
      return r;
   endfunction

   function automatic logic misal(input logic [1:0] a, input logic [2:0] op);
      return (op[1:0] == 2'b01 && a[0]) || (op[1:0] == 2'b10 && a != 2'b00);
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [1:0]  a,
                                           input logic [2:0]  op);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(w >> {a, 3'b000});
      h = a[1] ? w[31:16] : w[15:0];
      unique case (1'b1)
         op[1:0] == 2'b00: r = {{24{b[7] & ~op[2]}}, b};
         op[1:0] == 2'b01: r = {{16{h[15] & ~op[2]}}, h};
         default:          r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w,
                                         input logic [1:0]  a,
                                         input logic [2:0]  op,
                                         input logic [15:0] d);
      logic [31:0] r;
      r = w;
      if (op[1:0] == 2'b00) r[{a, 3'b000} +: 8] = d[7:0];
      else                  r[{a[1], 4'b0000} +: 16] = d;
      return r;
   endfunction

   assign unused_addr = ^dmemaddr[31:AW+2];
   assign rd_req      = dmemrdclk & ~rd_q;
   assign wr_req      = dmemwrclk & ~wr_q & dmemwe;
   assign st_op       = norm_op(dmemop);
   assign ld_addr     = pend_q ? pend_addr_q : dmemaddr[AW+1:0];
   assign ld_op       = pend_q ? pend_op_q : st_op;

   // Next-state, RAM port and output computation for the responder FSM
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      op_d        = op_q;
      data_d      = data_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      pend_op_d   = pend_op_q;
      dout_d      = dout_q;
      err_d       = 1'b0;
      ram_we      = 1'b0;
      ram_waddr   = addr_q[AW+1:2];
      ram_wdata   = '0;
      ram_raddr   = addr_q[AW+1:2];
      unique case (state_q)
         S_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            cnt_d     = cnt_q + AW'(1);
            if (cnt_q == '1) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (pend_q || (rd_req && !wr_req)) begin
               pend_d = 1'b0;
               if (ALIGN_CHK && misal(ld_addr[1:0], ld_op)) begin
                  dout_d = '0;
                  err_d  = 1'b1;
               end else begin
                  addr_d    = ld_addr;
                  op_d      = ld_op;
                  ram_raddr = ld_addr[AW+1:2];
                  state_d   = S_READ;
               end
            end else if (wr_req) begin
               if (rd_req) begin
                  pend_d      = 1'b1;
                  pend_addr_d = dmemaddr[AW+1:0];
                  pend_op_d   = st_op;
               end
               if (ALIGN_CHK && misal(dmemaddr[1:0], st_op)) begin
                  err_d = 1'b1;
               end else if (st_op[1:0] == 2'b10) begin
                  ram_we    = 1'b1;
                  ram_waddr = dmemaddr[AW+1:2];
                  ram_wdata = dmemdatain;
               end else begin
                  addr_d    = dmemaddr[AW+1:0];
                  op_d      = st_op;
                  data_d    = dmemdatain[15:0];
                  ram_raddr = dmemaddr[AW+1:2];
                  state_d   = S_RMW;
               end
            end
         end
         S_READ: begin
            dout_d  = extract(ram_rdata_q, addr_q[1:0], op_q);
            state_d = S_IDLE;
         end
         S_RMW: begin
            ram_we    = 1'b1;
            ram_waddr = addr_q[AW+1:2];
            ram_wdata = merge(ram_rdata_q, addr_q[1:0], op_q, data_q);
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE) && !pend_d;
   end

   // Control state and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= RST_STATE;
         cnt_q       <= '0;
         addr_q      <= '0;
         op_q        <= '0;
         data_q      <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_op_q   <= '0;
         dout_q      <= '0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         op_q        <= op_d;
         data_q      <= data_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_op_q   <= pend_op_d;
         dout_q      <= dout_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         rd_q        <= dmemrdclk;
         wr_q        <= dmemwrclk;
      end
   end

   // Word array with registered read; contents come from the clear sweep
   always_ff @(posedge clock) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      ram_rdata_q <= mem[ram_raddr];
   end

   assign dmemdataout = dout_q;
   assign dmemready   = ready_q;
   assign dmemerr     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: random loads/stores against a byte-level model,
// expected results queued at issue and checked when dmemready rises.
module tb_dmem_responder;

   localparam int AW = 10;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ACHK = 1'b1;
`else
   localparam bit ACHK = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] dmemaddr = '0;
   logic [31:0] dmemdatain = '0;
   logic [2:0]  dmemop = '0;
   logic        dmemwe = 1'b0;
   logic        dmemrdclk = 1'b0;
   logic        dmemwrclk = 1'b0;
   logic [31:0] dmemdataout;
   logic        dmemready;
   logic        dmemerr;

   dmem_responder #(.AW(AW), .CLEAR_EN(1'b1)) dut (
      .clock(clock), .reset(reset),
      .dmemaddr(dmemaddr), .dmemdatain(dmemdatain), .dmemop(dmemop),
      .dmemwe(dmemwe), .dmemrdclk(dmemrdclk), .dmemwrclk(dmemwrclk),
      .dmemdataout(dmemdataout), .dmemready(dmemready), .dmemerr(dmemerr)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] mem [int];
   logic [31:0] last_out = '0;
   logic        prev_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference model: operations described by size in bytes and offset
   function automatic logic [2:0] nop(input logic [2:0] op);
      if (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) return op;
      return 3'd2;
   endfunction

   function automatic int size_of(input logic [2:0] op);
      if (op[1:0] == 2'b00) return 1;
      if (op[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit misal(input logic [31:0] a, input logic [2:0] op);
      return (int'(a[1:0]) % size_of(op)) != 0;
   endfunction

   function automatic logic [31:0] rd_mem(input int wi);
      if (mem.exists(wi)) return mem[wi];
      return 32'h0;
   endfunction

   function automatic logic [31:0] ld_val(input logic [31:0] w,
                                          input logic [31:0] a,
                                          input logic [2:0]  op);
      int sz = size_of(op);
      int off = (int'(a[1:0]) / sz) * sz;
      logic [31:0] mask, v;
      if (sz == 4) return w;
      mask = (32'h1 << (8 * sz)) - 32'h1;
      v = (w >> (8 * off)) & mask;
      if (!op[2] && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] st_val(input logic [31:0] w,
                                          input logic [31:0] a,
                                          input logic [2:0]  op,
                                          input logic [31:0] d);
      int sz = size_of(op);
      int off = (int'(a[1:0]) / sz) * sz;
      logic [31:0] mask;
      if (sz == 4) return d;
      mask = ((32'h1 << (8 * sz)) - 32'h1) << (8 * off);
      return (w & ~mask) | ((d << (8 * off)) & mask);
   endfunction

   // Monitor: each rising dmemready completes the oldest queued expectation
   always @(negedge clock) begin
      if (dmemready && !prev_rdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready: ready rose at cycle %0d, nothing expected", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("dataout", dmemdataout, mon_e.data);
            check("latency", cyc, mon_e.cyc);
         end
      end
      prev_rdy = dmemready;
   end

   task automatic wait_ready(input int bound);
      int n = 0;
      while (!dmemready && n < bound) begin
         @(negedge clock);
         n++;
      end
      if (!dmemready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: ready=%0b want 1", dmemready);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      dmemrdclk = 1'b0;
      dmemwrclk = 1'b0;
      dmemwe    = 1'b0;
      exp_q.delete();
      mem.delete();
      last_out = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_dataout", dmemdataout, 32'h0);
      check("rst_ready", {31'b0, dmemready}, 32'h0);
      check("rst_err", {31'b0, dmemerr}, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      exp_q.push_back('{data: 32'h0, cyc: cyc + (2 ** AW)});
      wait_ready(2 ** AW + 100);
   endtask

   task automatic do_op(input bit rs, input bit ws, input bit we,
                        input logic [31:0] a, input logic [2:0] op,
                        input logic [31:0] d, input string name);
      logic [2:0] o;
      int  wi, sz, t0;
      bit  wr, mis, pushed, err_exp;
      wait_ready(100);
      @(posedge clock);
      #1;
      dmemaddr   = a;
      dmemop     = op;
      dmemdatain = d;
      dmemwe     = we;
      dmemrdclk  = rs;
      dmemwrclk  = ws;
      t0      = cyc;
      o       = nop(op);
      sz      = size_of(o);
      wi      = int'(a[AW+1:2]);
      wr      = ws && we;
      mis     = ACHK && misal(a, o);
      pushed  = 1'b0;
      err_exp = 1'b0;
      if (wr) begin
         if (mis) err_exp = 1'b1;
         else begin
            mem[wi] = st_val(rd_mem(wi), a, o, d);
            if (sz != 4 && !rs) begin
               exp_q.push_back('{data: last_out, cyc: t0 + 2});
               pushed = 1'b1;
            end
         end
      end
      if (rs) begin
         if (wr) begin
            last_out = ld_val(rd_mem(wi), a, o);
            exp_q.push_back('{data: last_out, cyc: t0 + ((sz == 4) ? 3 : 4)});
            pushed = 1'b1;
         end else if (mis) begin
            last_out = '0;
            err_exp  = 1'b1;
         end else begin
            last_out = ld_val(rd_mem(wi), a, o);
            exp_q.push_back('{data: last_out, cyc: t0 + 2});
            pushed = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      dmemrdclk = 1'b0;
      dmemwrclk = 1'b0;
      dmemwe    = 1'b0;
      @(negedge clock);
      check({name, "_err"}, {31'b0, dmemerr}, {31'b0, err_exp});
      if (!pushed) check({name, "_hold"}, dmemdataout, last_out);
      @(negedge clock);
      check({name, "_err_end"}, {31'b0, dmemerr}, 32'h0);
      repeat (3) @(posedge clock);
   endtask

   initial begin
      logic [31:0] a, d;
      logic [2:0]  op;
      int          kind, sz;

      do_reset();
      do_op(1, 0, 0, 32'h10, 3'd2, 32'h0, "lw10");

      do_op(0, 1, 1, 32'h20, 3'd2, 32'h12345678, "sw20");
      do_op(1, 0, 0, 32'h20, 3'd2, 32'h0, "lw20");
      do_op(1, 0, 0, 32'h21, 3'd0, 32'h0, "lb21");
      do_op(1, 0, 0, 32'h23, 3'd4, 32'h0, "lbu23");
      do_op(1, 0, 0, 32'h22, 3'd1, 32'h0, "lh22");

      do_op(0, 1, 1, 32'h21, 3'd0, 32'hAB, "sb21");
      do_op(1, 0, 0, 32'h20, 3'd2, 32'h0, "lw20b");
      do_op(1, 0, 0, 32'h21, 3'd0, 32'h0, "lb21b");

      do_op(0, 1, 1, 32'h22, 3'd1, 32'h8001, "sh22");
      do_op(1, 0, 0, 32'h22, 3'd1, 32'h0, "lh22b");
      do_op(1, 0, 0, 32'h22, 3'd5, 32'h0, "lhu22");

      do_op(1, 1, 1, 32'h40, 3'd2, 32'hCAFEF00D, "swlw40");
      do_op(1, 1, 1, 32'h45, 3'd0, 32'h5A, "sblb45");
      do_op(1, 0, 0, 32'h41, 3'd2, 32'h0, "lw41");
      do_op(0, 1, 0, 32'h40, 3'd2, 32'h0, "nowe40");
      do_op(1, 0, 0, 32'h40, 3'd2, 32'h0, "lw40");
      do_op(1, 0, 0, 32'hFFFF_F040, 3'd6, 32'h0, "wrap40");

      for (int i = 0; i < 400; i++) begin
         kind = $urandom_range(0, 9);
         a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
         op   = 3'($urandom_range(0, 7));
         d    = $urandom;
         if (kind <= 3)      do_op(1, 0, 0, a, op, d, "rnd_ld");
         else if (kind <= 6) do_op(0, 1, 1, a, op, d, "rnd_st");
         else if (kind == 7) begin
            sz = size_of(nop(op));
            a  = a & ~32'(sz - 1);
            do_op(1, 1, 1, a, op, d, "rnd_both");
         end else if (kind == 8) do_op(0, 1, 0, a, op, d, "rnd_nowe");
         else do_op(1, 0, 1, a, op, d, "rnd_ldwe");
      end

      do_op(0, 1, 1, 32'h60, 3'd2, 32'h11223344, "sw60");
      wait_ready(100);
      @(posedge clock);
      #1;
      dmemaddr   = 32'h61;
      dmemop     = 3'd0;
      dmemdatain = 32'hEE;
      dmemwe     = 1'b1;
      dmemwrclk  = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      do_reset();
      do_op(1, 0, 0, 32'h60, 3'd2, 32'h0, "lw60_after_rst");
      do_op(1, 0, 0, 32'h20, 3'd2, 32'h0, "lw20_after_rst");

      repeat (10) @(posedge clock);
      check("queue_empty", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
